// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 core constants for the writeback / register file slice
//
// Contents:
//   XLEN        data width of registers and writeback buses
//   REG_ADDR_W  register index width
//   NUM_REGS    architectural register count (x0 included)
//   REG_ZERO    index of the hardwired-zero register
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// rtl/wb_mux.sv - 3-way writeback value select, shared with the EX forwarding path
//
// Ports:
//   alu_jump  in   XLEN  ALU result / jump link address
//   mem       in   XLEN  load data
//   imm       in   XLEN  immediate (LUI)
//   sel_lw    in   1     pick load data (highest priority)
//   sel_lui   in   1     pick immediate (only when sel_lw=0)
//   data      out  XLEN  selected value
module wb_mux
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] alu_jump,
  input  logic [W-1:0] mem,
  input  logic [W-1:0] imm,
  input  logic         sel_lw,
  input  logic         sel_lui,
  output logic [W-1:0] data
);

  always_comb begin
    data = alu_jump;
    if (sel_lw) begin
      data = mem;
    end else if (sel_lui) begin
      data = imm;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage plus x0..x31 register file with retired-write counter
//
// Optional feature macro: WB_REGFILE_BYPASS_EN (write-through of the WB value onto the read ports)
//
// Ports:
//   clk          in   1      clock, all state on posedge
//   reset        in   1      synchronous active-high reset
//   wb_alu_jump  in   XLEN   ALU result / jump link address from MEM/WB
//   wb_mem       in   XLEN   load data from MEM/WB
//   wb_imm       in   XLEN   immediate from MEM/WB
//   wb_rd        in   5      destination register index
//   wb_esc_reg   in   1      register write enable
//   wb_lw        in   1      select load data
//   wb_lui       in   1      select immediate
//   rs1_addr     in   5      read port 1 index
//   rs2_addr     in   5      read port 2 index
//   rs1_data     out  XLEN   read port 1 data (combinational)
//   rs2_data     out  XLEN   read port 2 data (combinational)
//   wb_data      out  XLEN   selected writeback value
//   wb_we        out  1      effective write strobe
//   retired_cnt  out  CNT_W  committed register write count
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       wb_alu_jump,
  input  logic [XLEN-1:0]       wb_mem,
  input  logic [XLEN-1:0]       wb_imm,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_esc_reg,
  input  logic                  wb_lw,
  input  logic                  wb_lui,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_we,
  output logic [CNT_W-1:0]      retired_cnt
);

  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [CNT_W-1:0] cnt_q;

  wb_mux #(.W(XLEN)) u_wb_mux (
    .alu_jump (wb_alu_jump),
    .mem      (wb_mem),
    .imm      (wb_imm),
    .sel_lw   (wb_lw),
    .sel_lui  (wb_lui),
    .data     (wb_data)
  );

  // The MEM/WB bubble (esc_reg=1, rd=0) must not commit or count.
  assign wb_we = wb_esc_reg && (wb_rd != REG_ZERO);

  // regs[0] is cleared on reset and never written, but reads of index 0
  // are forced to zero anyway so the x0 guarantee does not depend on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      cnt_q <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
      cnt_q       <= cnt_q + CNT_W'(1);
    end
  end

  assign retired_cnt = cnt_q;

  always_comb begin
    rs1_data = (rs1_addr == REG_ZERO) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == REG_ZERO) ? '0 : regs[rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
    // Write-through: wb_we already excludes rd=0, so x0 stays zero here too.
    if (wb_we && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
    end
    if (wb_we && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
    end
`else
    // No write-through: the decode stage sees the pre-write value and the
    // hazard unit stalls one cycle on a WB->ID RAW dependency.
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard testbench for wb_regfile
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] wb_alu_jump;
  logic [31:0] wb_mem;
  logic [31:0] wb_imm;
  logic [4:0]  wb_rd;
  logic        wb_esc_reg;
  logic        wb_lw;
  logic        wb_lui;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] retired_cnt;

  wb_regfile dut (
    .clk         (clk),
    .reset       (reset),
    .wb_alu_jump (wb_alu_jump),
    .wb_mem      (wb_mem),
    .wb_imm      (wb_imm),
    .wb_rd       (wb_rd),
    .wb_esc_reg  (wb_esc_reg),
    .wb_lw       (wb_lw),
    .wb_lui      (wb_lui),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [31:0] ref_wb();
    if (wb_lw) return wb_mem;
    if (wb_lui) return wb_imm;
    return wb_alu_jump;
  endfunction

  function automatic logic ref_we();
    return wb_esc_reg && (wb_rd != 5'd0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (ref_we() && (a == wb_rd)) return ref_wb();
`endif
    return m_regs[a];
  endfunction

  task automatic drive(input logic [4:0] rd, input logic esc, input logic lw, input logic lui,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] imm);
    wb_rd       = rd;
    wb_esc_reg  = esc;
    wb_lw       = lw;
    wb_lui      = lui;
    wb_alu_jump = alu;
    wb_mem      = mem;
    wb_imm      = imm;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // Clock edge: model tracks what the DUT should commit, then return at negedge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (ref_we()) begin
      m_regs[wb_rd] = ref_wb();
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    sb_push({tag, "_rs1"}, ref_read(a1));
    sb_push({tag, "_rs2"}, ref_read(a2));
    sb_push({tag, "_wbdata"}, ref_wb());
    sb_push({tag, "_wbwe"}, {31'd0, ref_we()});
    #1;
    sb_pop(rs1_data);
    sb_pop(rs2_data);
    sb_pop(wb_data);
    sb_pop({31'd0, wb_we});
  endtask

  task automatic cnt_chk(input string tag);
    sb_push(tag, m_cnt);
    sb_pop(retired_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt    = 32'd0;
    reset    = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle();
    @(negedge clk);

    // 1. reset then read every index on both ports
    step();
    reset = 1'b0;
    cnt_chk("rst_cnt");
    for (int i = 0; i < 16; i++) begin
      read_chk("rst_rd", 5'(2 * i), 5'(2 * i + 1));
      step();
    end

    // 2. ALU writeback into x5
    drive(5'd5, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0, 32'd0);
    read_chk("alu_wr", 5'd1, 5'd2);
    step();
    idle();
    read_chk("alu_rd", 5'd5, 5'd5);
    cnt_chk("alu_cnt");

    // 3. x0 destination is discarded and not counted
    drive(5'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h1234, 32'd0);
    read_chk("x0_wr", 5'd5, 5'd0);
    step();
    idle();
    read_chk("x0_rd", 5'd0, 5'd0);
    cnt_chk("x0_cnt");

    // 4. load beats immediate, then immediate beats ALU
    drive(5'd7, 1'b1, 1'b1, 1'b1, 32'hC, 32'hA, 32'hB);
    read_chk("prio_lw", 5'd7, 5'd0);
    step();
    drive(5'd7, 1'b1, 1'b0, 1'b1, 32'hC, 32'hA, 32'hB);
    read_chk("prio_lui", 5'd7, 5'd5);
    step();
    idle();
    read_chk("prio_rd", 5'd7, 5'd5);

    // 5. same-cycle RAW on x9 (old value 0x11 first)
    drive(5'd9, 1'b1, 1'b0, 1'b0, 32'h11, 32'd0, 32'd0);
    step();
    drive(5'd9, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 32'd0);
    read_chk("raw_same", 5'd9, 5'd9);
    step();
    idle();
    read_chk("raw_next", 5'd9, 5'd9);
    cnt_chk("raw_cnt");

    // 6a. counter wrap
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    cnt_chk("wrap_pre");
    drive(5'd4, 1'b1, 1'b0, 1'b0, 32'h44, 32'd0, 32'd0);
    step();
    idle();
    cnt_chk("wrap_post");

    // 6b. reset wins over a concurrent write
    drive(5'd3, 1'b1, 1'b0, 1'b0, 32'h33, 32'd0, 32'd0);
    step();
    idle();
    read_chk("pre_rst", 5'd3, 5'd4);
    drive(5'd3, 1'b1, 1'b0, 1'b0, 32'h77, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    read_chk("rst_win", 5'd3, 5'd9);
    cnt_chk("rst_win_cnt");

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      read_chk("rnd", 5'($urandom_range(0, 31)), (i % 4 == 0) ? wb_rd : 5'($urandom_range(0, 31)));
      step();
      cnt_chk("rnd_cnt");
    end

    if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
